prism_cfg_sequencer: RTL
========================

// Module: prism_cfg_sequencer
// PURPOSE
//   Sequences PRISM (re)configuration: buffers (addr,data) debug writes from the host, then on 'go'
//   disables the FSM, pulses debug_reset, drains the buffer into the PRISM debug write port and
//   optionally re-enables the FSM. Arbitrates that port between the loader and direct host writes.
//   Sits between the TinyQV peripheral register decode and the prism controller instance.
// PARAMETERS
//   DEPTH         8   command FIFO entries (power of 2, >=2)
//   AW            6   debug address width
//   DW            32  debug data width
//   RESET_CYCLES  2   debug_reset pulse length in clocks (>=1)
// PORTS
//   clk          in   1      clock
//   rst          in   1      asynchronous active-high reset
//   cmd_valid    in   1      host pushes a queued config write
//   cmd_ready    out  1      FIFO accepts push (= !full && state!=LOAD)
//   cmd_addr     in   AW     queued write address
//   cmd_data     in   DW     queued write data
//   flush        in   1      empty FIFO (honoured in IDLE/RUN only)
//   go           in   1      start load sequence (pulse)
//   stop         in   1      drop FSM enable, return to IDLE (pulse)
//   auto_enable  in   1      after load: 1 -> RUN, 0 -> IDLE
//   err_clr      in   1      clear sticky err bits
//   host_wr      in   1      direct debug write request
//   host_addr    in   AW     direct write address
//   host_wdata   in   DW     direct write data
//   dbg_wr       out  1      to prism debug_wr (registered)
//   dbg_addr     out  AW     to prism debug_addr (registered)
//   dbg_wdata    out  DW     to prism debug_wdata (registered)
//   dbg_reset    out  1      to prism debug_reset (registered)
//   fsm_enable   out  1      to prism fsm_enable (registered)
//   busy         out  1      1 in DISABLE/RESET/LOAD
//   done         out  1      1-cycle pulse on load completion
//   level        out  $clog2(DEPTH)+1  FIFO occupancy
//   err          out  2      sticky: [0] push while full, [1] host_wr dropped while busy
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, FIFO empty, all outputs 0, err=0, level=0.
//   States: IDLE, DISABLE, RESET, LOAD, RUN.
//   - IDLE: fsm_enable=0. go -> DISABLE.
//   - RUN: fsm_enable=1. stop -> IDLE; go (no stop) -> DISABLE. go&&stop same cycle: stop wins.
//   - DISABLE: one cycle, fsm_enable=0, then RESET.
//   - RESET: dbg_reset=1 for exactly RESET_CYCLES clocks (down-counter), then LOAD.
//   - LOAD: one FIFO pop per clock; popped entry appears on dbg_wr/addr/wdata next cycle, dbg_wr=1
//     for that cycle only. Empty FIFO -> exit. Exit: done=1 one cycle; auto_enable sampled at exit.
//     Empty FIFO at go: LOAD lasts 1 cycle, zero writes, done still pulses.
//   - go/stop in DISABLE/RESET/LOAD ignored.
//   FIFO: circular, ptrs wrap mod DEPTH; level in 0..DEPTH. Push when cmd_valid&&cmd_ready.
//     cmd_valid while full (outside LOAD) -> entry dropped, err[0]<=1. cmd_valid during LOAD
//     stalled (cmd_ready=0), not an error. flush in IDLE/RUN: level->0 next cycle; push same cycle
//     as flush is discarded. flush elsewhere ignored.
//   Host arbitration: in IDLE/RUN host_wr drives dbg_* with 1-cycle latency (registered). In
//     busy states host_wr is dropped and err[1]<=1. Loader never shares a cycle with host.
//   err_clr clears err; simultaneous err set and err_clr: set wins.
//   dbg_addr/dbg_wdata hold last value when dbg_wr=0.
// TESTING
//   1. Push 3 cmds (0x04/0xA, 0x08/0xB, 0x0C/0xC), go, auto_enable=1 -> fsm_enable 0, dbg_reset
//      high 2 clk, 3 consecutive dbg_wr in FIFO order, done pulse, fsm_enable=1, level=0.
//   2. Push 9 cmds with DEPTH=8 -> cmd_ready=0 at level 8, err=2'b01; err_clr -> err=0.
//   3. During LOAD assert host_wr -> no dbg_wr from host, err[1]=1; in RUN host_wr 0x10/0x55 ->
//      dbg_wr with addr 0x10 data 0x55 one clock later.
//   4. go with empty FIFO, auto_enable=0 -> no dbg_wr, done pulse, return IDLE, fsm_enable=0.
//   5. go and stop same cycle in RUN -> IDLE, fsm_enable=0, no dbg_reset.
//   6. Assert rst mid-LOAD (2 of 5 written) -> outputs 0 immediately, level=0, IDLE after release.

Source files
------------

// File: rtl/prism_cfg_sequencer_if.sv
// Host-side bundle between the peripheral register decode and the PRISM configuration sequencer.
interface prism_cfg_sequencer_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 32
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          flush;
  logic          go;
  logic          stop;
  logic          auto_enable;
  logic          err_clr;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          dbg_wr;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_reset;
  logic          fsm_enable;
  logic          busy;
  logic          done;
  logic [LW-1:0] level;
  logic [1:0]    err;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, flush, go, stop, auto_enable, err_clr,
           host_wr, host_addr, host_wdata,
    input  cmd_ready, dbg_wr, dbg_addr, dbg_wdata, dbg_reset, fsm_enable, busy, done,
           level, err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, flush, go, stop, auto_enable, err_clr,
           host_wr, host_addr, host_wdata,
    output cmd_ready, dbg_wr, dbg_addr, dbg_wdata, dbg_reset, fsm_enable, busy, done,
           level, err
  );
endinterface

// File: rtl/prism_cfg_sequencer.sv
// PRISM (re)configuration sequencer: queues host debug writes, then disables the FSM,
// pulses debug_reset, replays the queue into the debug port and optionally re-enables.
module prism_cfg_sequencer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AW           = 6,
  parameter int unsigned DW           = 32,
  parameter int unsigned RESET_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  prism_cfg_sequencer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DISABLE, S_RESET, S_LOAD, S_RUN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] rst_cnt;
  logic [CW-1:0] rst_cnt_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic          host_ok;
  logic          host_acc;
  logic          clear;
  logic          push;
  logic          pop;
  logic          done_nxt;
  logic [LW-1:0] level_nxt;
  logic [1:0]    err_nxt;

  // State and reset-pulse counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rst_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rst_cnt <= rst_cnt_nxt;
    end
  end

  // Next state, FIFO control, arbitration and sticky error update
  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    pop         = 1'b0;
    done_nxt    = 1'b0;
    host_ok     = (state == S_IDLE) || (state == S_RUN);
    case (state)
      S_IDLE:    if (bus.go) state_nxt = S_DISABLE;
      S_RUN: begin
        if (bus.stop)    state_nxt = S_IDLE;
        else if (bus.go) state_nxt = S_DISABLE;
      end
      S_DISABLE: begin
        state_nxt   = S_RESET;
        rst_cnt_nxt = CW'(RESET_CYCLES - 1);
      end
      S_RESET: begin
        if (rst_cnt == '0) state_nxt = S_LOAD;
        else               rst_cnt_nxt = rst_cnt - CW'(1);
      end
      S_LOAD: begin
        if (bus.level == '0) begin
          state_nxt = bus.auto_enable ? S_RUN : S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
    host_acc  = host_ok && bus.host_wr;
    clear     = host_ok && bus.flush;
    push      = bus.cmd_valid && bus.cmd_ready && !clear;
    level_nxt = clear ? '0 : (bus.level + LW'(push) - LW'(pop));
    err_nxt   = bus.err_clr ? 2'b00 : bus.err;
    if (bus.cmd_valid && (bus.level == LW'(DEPTH)) && (state != S_LOAD)) err_nxt[0] = 1'b1;
    if (bus.host_wr && !host_ok) err_nxt[1] = 1'b1;
  end

  // Command payload storage; contents are qualified by the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= bus.cmd_addr;
      mem_data[wr_ptr] <= bus.cmd_data;
    end
  end

  // FIFO pointers and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      bus.level      <= '0;
      bus.err        <= '0;
      bus.cmd_ready  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.fsm_enable <= 1'b0;
      bus.dbg_reset  <= 1'b0;
      bus.dbg_wr     <= 1'b0;
      bus.dbg_addr   <= '0;
      bus.dbg_wdata  <= '0;
    end else begin
      bus.level      <= level_nxt;
      bus.err        <= err_nxt;
      bus.done       <= done_nxt;
      bus.cmd_ready  <= (level_nxt != LW'(DEPTH)) && (state_nxt != S_LOAD);
      bus.busy       <= state_nxt inside {S_DISABLE, S_RESET, S_LOAD};
      bus.fsm_enable <= (state_nxt == S_RUN);
      bus.dbg_reset  <= (state_nxt == S_RESET);
      bus.dbg_wr     <= pop || host_acc;
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      if (pop) begin
        bus.dbg_addr  <= mem_addr[rd_ptr];
        bus.dbg_wdata <= mem_data[rd_ptr];
      end else if (host_acc) begin
        bus.dbg_addr  <= bus.host_addr;
        bus.dbg_wdata <= bus.host_wdata;
      end
    end
  end
endmodule
